el2_ifu_bht_upd_ctl: RTL and testbench

//  Consumer of the resolved-branch history updates produced at EXU branch resolution: ataken/misp drive the
//  2-bit newhist, which is written back to the branch history table (BHT) here. Holds a small coalescing

---
 rtl/el2_ifu_bht_upd_ctl_if.sv | 32 +++
 rtl/el2_ifu_bht_upd_ctl.sv | 231 +++++++++++++++++++++++
 tb/tb_el2_ifu_bht_upd_ctl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_ifu_bht_upd_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : el2_ifu_bht_upd_ctl_if
// Description : EXU branch-history update and fetch-side BHT lookup bundle.
//               The master side (EXU/fetch) drives updates and lookups. The
//               slave side (BHT update control) returns lookup results.
// Revision    : 1.0  initial release
// ============================================================================
interface el2_ifu_bht_upd_ctl_if #(
  parameter int BHT_IDX_W = 8
);
  logic                 exu_bht_upd_valid;
  logic [BHT_IDX_W-1:0] exu_bht_upd_index;
  logic [1:0]           exu_bht_upd_hist;
  logic                 ifu_bht_rd_en;
  logic [BHT_IDX_W-1:0] ifu_bht_rd_index;
  logic                 bht_rd_valid;
  logic [1:0]           bht_rd_hist;

  modport master (
    output exu_bht_upd_valid, exu_bht_upd_index, exu_bht_upd_hist,
    output ifu_bht_rd_en, ifu_bht_rd_index,
    input  bht_rd_valid, bht_rd_hist
  );

  modport slave (
    input  exu_bht_upd_valid, exu_bht_upd_index, exu_bht_upd_hist,
    input  ifu_bht_rd_en, ifu_bht_rd_index,
    output bht_rd_valid, bht_rd_hist
  );
endinterface
`default_nettype wire

// File: rtl/el2_ifu_bht_upd_ctl.sv
`default_nettype none
// ============================================================================
// Module      : el2_ifu_bht_upd_ctl
// Description : Branch history table write-back control. Resolved-branch
//               history updates are coalesced in a small queue. The queue is
//               drained into a single-port 2-bit BHT array. Fetch lookups are
//               served with bypass from the queue and the incoming update.
// Revision    : 1.0  initial release
// ============================================================================
module el2_ifu_bht_upd_ctl #(
  parameter int BHT_IDX_W = 8,
  parameter int QDEPTH    = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_l,
  input  wire logic              scan_mode,
  el2_ifu_bht_upd_ctl_if.slave   bus,
  output logic                   bht_init_done,
  output logic                   bht_q_full,
  output logic [15:0]            bht_upd_drop_cnt
);

  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRIES = 1 << BHT_IDX_W;

  localparam logic [BHT_IDX_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [BHT_IDX_W-1:0] IDX_ONE  = BHT_IDX_W'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [BHT_IDX_W-1:0] init_cnt;

  // BHT storage and update queue payload (not reset: INIT rewrites the
  // array, and queue payload is qualified by q_vld)
  logic [1:0]           bht_arr [ENTRIES];
  logic [BHT_IDX_W-1:0] q_idx   [QDEPTH];
  logic [1:0]           q_hist  [QDEPTH];
  logic [QDEPTH-1:0]    q_vld;
  logic [PTR_W-1:0]     q_head;
  logic [PTR_W-1:0]     q_tail;
  logic [CNT_W-1:0]     q_count;
  logic [CNT_W-1:0]     q_count_nxt;

  logic                 upd_hit;
  logic [PTR_W-1:0]     upd_hit_slot;
  logic                 rd_hit;
  logic [PTR_W-1:0]     rd_hit_slot;
  logic                 run;
  logic                 drain;
  logic                 coalesce;
  logic                 push;
  logic                 drop;
  logic                 rd_go;
  logic [1:0]           drain_hist;
  logic [1:0]           rd_hist_nxt;
  logic                 arr_we;
  logic [BHT_IDX_W-1:0] arr_wa;
  logic [1:0]           arr_wd;

  // scan_mode only affects clock gating, which this block does not use
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  // Associative search of the queue for the update index and the lookup index
  always_comb begin
    upd_hit      = 1'b0;
    upd_hit_slot = '0;
    rd_hit       = 1'b0;
    rd_hit_slot  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i] && (q_idx[i] == bus.exu_bht_upd_index)) begin
        upd_hit      = 1'b1;
        upd_hit_slot = PTR_W'(i);
      end
      if (q_vld[i] && (q_idx[i] == bus.ifu_bht_rd_index)) begin
        rd_hit      = 1'b1;
        rd_hit_slot = PTR_W'(i);
      end
    end
  end

  // Queue control: drain when the read port is free, or forced when full
  assign run      = (state == ST_RUN);
  assign drain    = run && (q_count != '0) && (!bus.ifu_bht_rd_en || bht_q_full);
  assign coalesce = bus.exu_bht_upd_valid && upd_hit;
  assign push     = bus.exu_bht_upd_valid && !upd_hit && (!bht_q_full || drain);
  assign drop     = bus.exu_bht_upd_valid && !upd_hit && bht_q_full && !drain;
  assign rd_go    = run && bus.ifu_bht_rd_en && !drain;

  // A coalesce onto the draining head must reach the array
  assign drain_hist = (coalesce && (upd_hit_slot == q_head)) ? bus.exu_bht_upd_hist
                                                             : q_hist[q_head];

  // Next queue occupancy
  always_comb begin
    q_count_nxt = q_count;
    if (push && !drain) begin
      q_count_nxt = q_count + CNT_ONE;
    end else if (!push && drain) begin
      q_count_nxt = q_count - CNT_ONE;
    end
  end

  // Lookup result priority: this cycle's accepted update, then queue, then array
  always_comb begin
    rd_hist_nxt = bht_arr[bus.ifu_bht_rd_index];
    if (bus.exu_bht_upd_valid && !drop &&
        (bus.exu_bht_upd_index == bus.ifu_bht_rd_index)) begin
      rd_hist_nxt = bus.exu_bht_upd_hist;
    end else if (rd_hit && !(drain && (rd_hit_slot == q_head))) begin
      rd_hist_nxt = q_hist[rd_hit_slot];
    end
  end

  // Single array write port shared between initialisation and queue drain
  always_comb begin
    arr_we = 1'b0;
    arr_wa = '0;
    arr_wd = 2'b00;
    if (state == ST_INIT) begin
      arr_we = 1'b1;
      arr_wa = init_cnt;
      arr_wd = 2'b00;
    end else if (drain) begin
      arr_we = 1'b1;
      arr_wa = q_idx[q_head];
      arr_wd = drain_hist;
    end
  end

  // BHT array write
  always_ff @(posedge clk) begin
    if (arr_we) begin
      bht_arr[arr_wa] <= arr_wd;
    end
  end

  // Queue payload: coalesce overwrite or new tail entry
  always_ff @(posedge clk) begin
    if (coalesce) begin
      q_hist[upd_hit_slot] <= bus.exu_bht_upd_hist;
    end
    if (push) begin
      q_idx[q_tail]  <= bus.exu_bht_upd_index;
      q_hist[q_tail] <= bus.exu_bht_upd_hist;
    end
  end

  // Queue pointers, valid bits, occupancy and full flag
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      q_head     <= '0;
      q_tail     <= '0;
      q_count    <= '0;
      q_vld      <= '0;
      bht_q_full <= 1'b0;
    end else begin
      // clear before set: when full with a drain, tail and head share a slot
      if (drain) begin
        q_vld[q_head] <= 1'b0;
        q_head        <= q_head + PTR_ONE;
      end
      if (push) begin
        q_vld[q_tail] <= 1'b1;
        q_tail        <= q_tail + PTR_ONE;
      end
      q_count    <= q_count_nxt;
      bht_q_full <= (q_count_nxt == CNT_FULL);
    end
  end

  // Saturating dropped-update counter
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      bht_upd_drop_cnt <= 16'h0000;
    end else if (drop && (bht_upd_drop_cnt != 16'hFFFF)) begin
      bht_upd_drop_cnt <= bht_upd_drop_cnt + 16'd1;
    end
  end

  // Lookup response register; history holds when no lookup completes
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      bus.bht_rd_valid <= 1'b0;
      bus.bht_rd_hist  <= 2'b00;
    end else begin
      bus.bht_rd_valid <= rd_go;
      if (rd_go) begin
        bus.bht_rd_hist <= rd_hist_nxt;
      end
    end
  end

  // Initialisation FSM: sweep the array once, then stay in RUN until reset
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state         <= ST_INIT;
      init_cnt      <= '0;
      bht_init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == LAST_IDX) begin
            state         <= ST_RUN;
            bht_init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + IDX_ONE;
          end
        end
        ST_RUN: begin
          state         <= ST_RUN;
          bht_init_done <= 1'b1;
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_el2_ifu_bht_upd_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_el2_ifu_bht_upd_ctl
// Description : Self-checking bench for el2_ifu_bht_upd_ctl. Directed
//               scenarios followed by randomized traffic, all compared each
//               cycle against a queue/array reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_el2_ifu_bht_upd_ctl;

  localparam int IDXW = 8;
  localparam int QD   = 4;
  localparam int NENT = 1 << IDXW;

  logic        clk;
  logic        rst_l;
  logic        scan_mode;
  logic        bht_init_done;
  logic        bht_q_full;
  logic [15:0] bht_upd_drop_cnt;

  el2_ifu_bht_upd_ctl_if #(.BHT_IDX_W(IDXW)) bif ();

  el2_ifu_bht_upd_ctl #(.BHT_IDX_W(IDXW), .QDEPTH(QD)) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .scan_mode        (scan_mode),
    .bus              (bif),
    .bht_init_done    (bht_init_done),
    .bht_q_full       (bht_q_full),
    .bht_upd_drop_cnt (bht_upd_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // One comparison: count it, report it when it disagrees
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending (index, hist) pairs plus the table
  typedef struct {
    logic [IDXW-1:0] idx;
    logic [1:0]      hist;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  marr [NENT];
  bit          m_run;
  int          m_init_pos;
  logic        m_rdv;
  logic [1:0]  m_rdh;
  logic [15:0] m_drop;

  task automatic model_step(input logic rl, input logic uv, input logic [IDXW-1:0] ui,
                            input logic [1:0] uh, input logic re, input logic [IDXW-1:0] ri);
    bit   was_full, drn, rdv, found, accepted;
    int   k;
    ent_t e;
    if (!rl) begin
      mq.delete();
      m_run      = 0;
      m_init_pos = 0;
      m_rdv      = 1'b0;
      m_rdh      = 2'b00;
      m_drop     = 16'h0;
      return;
    end
    was_full = (mq.size() == QD);
    drn      = m_run && (mq.size() > 0) && (!re || was_full);
    rdv      = m_run && re && !drn;
    found    = 0;
    accepted = 0;
    if (uv) begin
      for (k = 0; k < mq.size(); k++) begin
        if (mq[k].idx == ui) begin
          mq[k].hist = uh;
          found = 1;
        end
      end
    end
    if (drn) begin
      marr[mq[0].idx] = mq[0].hist;
      void'(mq.pop_front());
    end
    if (uv && !found) begin
      if (!was_full || drn) begin
        e.idx  = ui;
        e.hist = uh;
        mq.push_back(e);
        accepted = 1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
    if (rdv) begin
      m_rdh = marr[ri];
      for (k = 0; k < mq.size(); k++) begin
        if (mq[k].idx == ri) m_rdh = mq[k].hist;
      end
    end
    m_rdv = rdv;
    if (!m_run) begin
      marr[m_init_pos] = 2'b00;
      if (m_init_pos == NENT - 1) m_run = 1;
      else m_init_pos++;
    end
    if (accepted && found) m_drop = m_drop;
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic rl, input logic uv, input logic [IDXW-1:0] ui,
                      input logic [1:0] uh, input logic re, input logic [IDXW-1:0] ri);
    rst_l                 = rl;
    bif.exu_bht_upd_valid = uv;
    bif.exu_bht_upd_index = ui;
    bif.exu_bht_upd_hist  = uh;
    bif.ifu_bht_rd_en     = re;
    bif.ifu_bht_rd_index  = ri;
    model_step(rl, uv, ui, uh, re, ri);
    @(posedge clk);
    #1;
    check("rd_valid",  {31'd0, bif.bht_rd_valid}, {31'd0, m_rdv});
    check("rd_hist",   {30'd0, bif.bht_rd_hist},  {30'd0, m_rdh});
    check("init_done", {31'd0, bht_init_done},    {31'd0, m_run});
    check("q_full",    {31'd0, bht_q_full},       {31'd0, (mq.size() == QD)});
    check("drop_cnt",  {16'd0, bht_upd_drop_cnt}, {16'd0, m_drop});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
  endtask

  // Idle until the sweep finishes, bounded
  task automatic wait_init();
    for (int c = 0; c < 300; c++) begin
      if (bht_init_done) break;
      idle();
    end
    check("init_timeout", {31'd0, bht_init_done}, 32'd1);
  endtask

  int done_at;

  initial begin
    scan_mode             = 1'b0;
    rst_l                 = 1'b0;
    bif.exu_bht_upd_valid = 1'b0;
    bif.exu_bht_upd_index = '0;
    bif.exu_bht_upd_hist  = 2'b00;
    bif.ifu_bht_rd_en     = 1'b0;
    bif.ifu_bht_rd_index  = '0;

    // 1: reset, sweep length, lookups ignored during INIT
    do_reset();
    done_at = 0;
    for (int c = 1; c <= 300; c++) begin
      step(1'b1, 1'b0, '0, 2'b00, (c < 20), 8'h10);
      if (bht_init_done) begin
        done_at = c;
        break;
      end
    end
    check("init_len", done_at, 256);

    // 2: queue bypass of a fresh update
    step(1'b1, 1'b1, 8'h05, 2'b11, 1'b0, '0);
    step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h05);
    check("t2_rdv",  {31'd0, bif.bht_rd_valid}, 32'd1);
    check("t2_hist", {30'd0, bif.bht_rd_hist},  32'd3);

    // 3: back-to-back updates to one index coalesce while reads hold the port
    step(1'b1, 1'b1, 8'h07, 2'b10, 1'b1, 8'h07);
    step(1'b1, 1'b1, 8'h07, 2'b01, 1'b1, 8'h07);
    step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h07);
    repeat (4) idle();
    step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h07);
    check("t3_hist", {30'd0, bif.bht_rd_hist}, 32'd1);

    // 4: continuous reads, five distinct updates; fifth forces a drain
    repeat (4) idle();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'h20 + 8'(i), 2'(i + 1), 1'b1, 8'h40);
      if (i == 3) check("t4_full", {31'd0, bht_q_full}, 32'd1);
    end
    check("t4_rdv",  {31'd0, bif.bht_rd_valid}, 32'd0);
    check("t4_drop", {16'd0, bht_upd_drop_cnt}, 32'd0);
    repeat (6) idle();

    // 5: five distinct updates during INIT, one dropped, rest survive
    do_reset();
    step(1'b1, 1'b1, 8'h30, 2'b11, 1'b0, '0);
    step(1'b1, 1'b1, 8'h31, 2'b10, 1'b0, '0);
    step(1'b1, 1'b1, 8'h32, 2'b01, 1'b0, '0);
    step(1'b1, 1'b1, 8'h33, 2'b11, 1'b0, '0);
    step(1'b1, 1'b1, 8'h34, 2'b10, 1'b0, '0);
    check("t5_drop", {16'd0, bht_upd_drop_cnt}, 32'd1);
    wait_init();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h30 + 8'(i));
      idle();
    end
    repeat (4) idle();
    step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h30);
    check("t5_rd30", {30'd0, bif.bht_rd_hist}, 32'd3);

    // 6: reset with three queued entries discards them
    do_reset();
    step(1'b1, 1'b1, 8'h50, 2'b11, 1'b0, '0);
    step(1'b1, 1'b1, 8'h51, 2'b11, 1'b0, '0);
    step(1'b1, 1'b1, 8'h52, 2'b11, 1'b0, '0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
    check("t6_done", {31'd0, bht_init_done},    32'd0);
    check("t6_full", {31'd0, bht_q_full},       32'd0);
    check("t6_drop", {16'd0, bht_upd_drop_cnt}, 32'd0);
    wait_init();
    step(1'b1, 1'b0, '0, 2'b00, 1'b1, 8'h50);
    check("t6_rd50", {30'd0, bif.bht_rd_hist}, 32'd0);

    // Randomized traffic over a small index pool with occasional reset
    for (int c = 0; c < 4000; c++) begin
      logic            rl, uv, re;
      logic [IDXW-1:0] ui, ri;
      logic [1:0]      uh;
      rl = ($urandom_range(0, 1999) != 0);
      uv = ($urandom_range(0, 2) != 0);
      ui = ($urandom_range(0, 7) == 0) ? IDXW'($urandom) : IDXW'($urandom_range(0, 7));
      uh = 2'($urandom);
      re = ($urandom_range(0, 3) != 0);
      ri = ($urandom_range(0, 7) == 0) ? IDXW'($urandom) : IDXW'($urandom_range(0, 7));
      step(rl, uv, ui, uh, re, ri);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
